// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spikes per channel over a programmable window
// and streams the counts out, one channel per beat, over a valid/ready port.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              counting enable (low clears the live counters and window)
//   spike_in[NCH]   one spike flag per channel
//   win_len[WIN_W]  window length in enabled cycles, 0 means 2^WIN_W
//   out_valid       a count beat is presented
//   out_ready       the consumer accepts the beat
//   out_chan[3]     channel index of the current beat
//   out_count       count for out_chan
//   out_last        high on the beat for channel NCH-1
//   overrun         sticky: a window ended while a drain was still in progress
module spike_rate_decoder #(
    parameter int NCH   = 5,
    parameter int CNT_W = 8,
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NCH-1:0]   spike_in,
    input  logic [WIN_W-1:0] win_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_chan,
    output logic [CNT_W-1:0] out_count,
    output logic             out_last,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CMAX    = '1;
    localparam logic [CNT_W-1:0] ONE_C   = 1;
    localparam logic [WIN_W-1:0] ONE_W   = 1;
    localparam logic [2:0]       LAST_CH = 3'(NCH - 1);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0] live [NCH];
    logic [CNT_W-1:0] snap [NCH];
    logic [CNT_W-1:0] inc  [NCH];

    logic [WIN_W-1:0] w;
    logic [WIN_W-1:0] lm1_q;
    logic [WIN_W-1:0] lm1;
    logic             win_end;
    logic             fire;
    logic             last_fire;
    logic             load;
    logic             adv;
    logic [2:0]       chan_inc;
    logic [CNT_W-1:0] cnt_nx;

    assign out_valid = (state == DRAIN);

    always_comb begin
        // Window length minus one; win_len=0 wraps to all ones = 2^WIN_W-1.
        // Sampled fresh at w=0, held for the rest of the window.
        lm1       = (w == '0) ? (win_len - ONE_W) : lm1_q;
        win_end   = en && (w == lm1);
        fire      = out_valid && out_ready;
        last_fire = fire && out_last;
        // A new snapshot is only taken if the port is free after this edge.
        load      = win_end && ((state == IDLE) || last_fire);
        adv       = fire && !out_last;
        chan_inc  = out_chan + 3'd1;
        cnt_nx    = '0;
        for (int i = 0; i < NCH; i++) begin
            inc[i] = (spike_in[i] && (live[i] != CMAX)) ?
                     (live[i] + ONE_C) : live[i];
            if (3'(i) == chan_inc) begin
                cnt_nx = snap[i];
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (load) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (last_fire && !load) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w         <= '0;
            lm1_q     <= '0;
            overrun   <= 1'b0;
            out_chan  <= '0;
            out_count <= '0;
            out_last  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                live[i] <= '0;
                snap[i] <= '0;
            end
        end else begin
            if (!en) begin
                w       <= '0;
                overrun <= 1'b0;
                for (int i = 0; i < NCH; i++) begin
                    live[i] <= '0;
                end
            end else begin
                if (w == '0) begin
                    lm1_q <= lm1;
                end
                if (win_end) begin
                    w <= '0;
                    for (int i = 0; i < NCH; i++) begin
                        live[i] <= '0;
                    end
                    if (!load) begin
                        overrun <= 1'b1;
                    end
                end else begin
                    w <= w + ONE_W;
                    for (int i = 0; i < NCH; i++) begin
                        live[i] <= inc[i];
                    end
                end
            end

            if (load) begin
                for (int i = 0; i < NCH; i++) begin
                    snap[i] <= inc[i];
                end
                out_chan  <= '0;
                out_count <= inc[0];
                out_last  <= (LAST_CH == 3'd0);
            end else if (adv) begin
                out_chan  <= chan_inc;
                out_count <= cnt_nx;
                out_last  <= (chan_inc == LAST_CH);
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: scoreboard bench for spike_rate_decoder.
// A reference model predicts beats into a queue; a monitor pops and compares.
module tb_spike_rate_decoder;

    localparam int NCH   = 5;
    localparam int CNT_W = 8;
    localparam int WIN_W = 8;
    localparam int CMAXV = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [NCH-1:0]   spike_in;
    logic [WIN_W-1:0] win_len;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_chan;
    logic [CNT_W-1:0] out_count;
    logic             out_last;
    logic             overrun;

    spike_rate_decoder #(
        .NCH   (NCH),
        .CNT_W (CNT_W),
        .WIN_W (WIN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .spike_in  (spike_in),
        .win_len   (win_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan),
        .out_count (out_count),
        .out_last  (out_last),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int chan;
        int count;
        bit last;
    } beat_t;

    beat_t q[$];
    beat_t staged[$];
    int    cnt [NCH];
    int    pos;
    int    len;
    bit    ovr_exp;
    bit    ovr_pend;
    int    checks;
    int    failures;

    // Monitor: compare whatever the DUT presents against the scoreboard.
    always @(negedge clk) begin
        checks++;
        if (out_valid !== (q.size() != 0)) begin
            failures++;
            $display("FAIL valid: got %b want %b", out_valid, q.size() != 0);
        end
        if (out_valid && q.size() != 0) begin
            checks++;
            if (int'(out_chan) != q[0].chan || int'(out_count) != q[0].count ||
                out_last !== q[0].last) begin
                failures++;
                $display("FAIL beat: got (%0d,%0d,%b) want (%0d,%0d,%b)",
                         out_chan, out_count, out_last,
                         q[0].chan, q[0].count, q[0].last);
            end
            if (out_ready) begin
                void'(q.pop_front());
            end
        end
        checks++;
        if (overrun !== ovr_exp) begin
            failures++;
            $display("FAIL overrun: got %b want %b", overrun, ovr_exp);
        end
    end

    function automatic void model_clear();
        for (int i = 0; i < NCH; i++) cnt[i] = 0;
        pos = 0;
    endfunction

    // One clock: commit what the last edge produced, then drive the inputs
    // for the coming edge and predict its effect from the window rules.
    task automatic step(input logic e, input logic [NCH-1:0] s,
                        input logic r, input logic [WIN_W-1:0] wl);
        beat_t b;
        @(posedge clk);
        #1;
        while (staged.size() != 0) q.push_back(staged.pop_front());
        ovr_exp = ovr_pend;
        en = e;
        spike_in = s;
        out_ready = r;
        win_len = wl;
        if (!e) begin
            model_clear();
            ovr_pend = 1'b0;
        end else begin
            if (pos == 0) len = (wl == 0) ? (1 << WIN_W) : int'(wl);
            for (int i = 0; i < NCH; i++) begin
                cnt[i] = cnt[i] + int'(s[i]);
                if (cnt[i] > CMAXV) cnt[i] = CMAXV;
            end
            if (pos == len - 1) begin
                if (q.size() == 0 || (q.size() == 1 && r)) begin
                    for (int i = 0; i < NCH; i++) begin
                        b.chan = i;
                        b.count = cnt[i];
                        b.last = (i == NCH - 1);
                        staged.push_back(b);
                    end
                end else begin
                    ovr_pend = 1'b1;
                end
                model_clear();
            end else begin
                pos++;
            end
        end
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if (out_valid !== 1'b0 || out_chan !== 3'd0 || out_count !== '0 ||
            out_last !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL %s: got v=%b ch=%0d cnt=%0d last=%b ovr=%b want all 0",
                     name, out_valid, out_chan, out_count, out_last, overrun);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        en = 1'b0;
        spike_in = '0;
        rst = 1'b1;
        #1;
        check_zero_outputs("reset_async");
        q.delete();
        staged.delete();
        model_clear();
        ovr_exp = 1'b0;
        ovr_pend = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        checks = 0;
        failures = 0;
        ovr_exp = 1'b0;
        ovr_pend = 1'b0;
        len = 1;
        model_clear();
        rst = 1'b1;
        en = 1'b0;
        spike_in = '0;
        out_ready = 1'b0;
        win_len = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset_state");
        rst = 1'b0;

        // Single active channel.
        step(1'b0, '0, 1'b1, 8'd4);
        for (int k = 0; k < 24; k++) step(1'b1, 5'b00001, 1'b1, 8'd4);

        // Saturation over a 256-cycle window.
        step(1'b0, '0, 1'b1, 8'd0);
        for (int k = 0; k < 530; k++) step(1'b1, 5'b11111, 1'b1, 8'd0);

        // Backpressure and overrun, then release, then en low clears overrun.
        step(1'b0, '0, 1'b1, 8'd4);
        for (int k = 0; k < 12; k++) step(1'b1, 5'b00010, 1'b0, 8'd4);
        for (int k = 0; k < 15; k++) step(1'b1, 5'b00010, 1'b1, 8'd4);
        for (int k = 0; k < 8; k++) step(1'b0, '0, 1'b1, 8'd4);

        // Back-to-back windows of length NCH.
        for (int k = 0; k < 40; k++)
            step(1'b1, NCH'($urandom), 1'b1, 8'd5);

        // Boundary spike in the last window cycle.
        step(1'b0, '0, 1'b1, 8'd3);
        for (int k = 0; k < 12; k++)
            step(1'b1, (k == 2) ? 5'b00100 : 5'b00000, 1'b1, 8'd3);

        // Randomized traffic, including mid-window win_len changes.
        step(1'b0, '0, 1'b1, 8'd4);
        for (int k = 0; k < 1500; k++)
            step($urandom_range(0, 39) != 0, NCH'($urandom),
                 $urandom_range(0, 3) != 0, WIN_W'($urandom_range(0, 9)));

        // Reset in the middle of a drain, after beat 2 has been accepted.
        step(1'b0, '0, 1'b1, 8'd4);
        guard = 0;
        while (!(q.size() == 2 && staged.size() == 0) && guard < 60) begin
            step(1'b1, NCH'($urandom), 1'b1, 8'd4);
            guard++;
        end
        checks++;
        if (guard >= 60) begin
            failures++;
            $display("FAIL middrain_reach: got no drain at beat 3 want one within 60 cycles");
        end
        do_reset();
        for (int k = 0; k < 20; k++)
            step(1'b1, NCH'($urandom), 1'b1, 8'd4);

        for (int k = 0; k < 10; k++) step(1'b0, '0, 1'b1, 8'd4);
        checks++;
        if (q.size() != 0 || staged.size() != 0) begin
            failures++;
            $display("FAIL drained: got %0d beats outstanding want 0",
                     q.size() + staged.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
